// File: rtl/prog_loader.sv
// Program loader and writable instruction store for the 4-bit CPU.
// Streams host bytes into a 16-word RAM, verifies an XOR checksum, then releases the CPU.
module prog_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] fetch_instr,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   load_count
);

  localparam logic [DW-1:0] HALT     = DW'(8'hF0);
  localparam logic [AW:0]   LAST_IDX = (AW+1)'(DEPTH-1);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, ERR} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] csum;
  logic          xfer;
  logic          wr_en;
  logic          clr;

  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE, RUN, ERR: begin
        if (start) begin
          state_nxt = LOAD;
          clr       = 1'b1;
        end
      end
      LOAD: begin
        if (xfer) begin
          wr_en = 1'b1;
          // The final slot without in_last means the host overran the store.
          if (in_last)                    state_nxt = CHECK;
          else if (load_count == LAST_IDX) state_nxt = ERR;
        end
      end
      CHECK: begin
        if (xfer) state_nxt = (in_data == csum) ? RUN : ERR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_count <= '0;
      csum       <= '0;
    end else if (clr) begin
      load_count <= '0;
      csum       <= '0;
    end else if (wr_en) begin
      load_count <= load_count + (AW+1)'(1);
      csum       <= csum ^ in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[load_count[AW-1:0]] <= in_data;
  end

  assign in_ready  = (state == LOAD) || (state == CHECK);
  assign busy      = in_ready;
  assign done      = (state == RUN);
  assign err       = (state == ERR);
  assign cpu_reset = (state != RUN);

  // Words beyond the current load are masked so stale RAM never reaches the CPU.
  assign fetch_instr = ({1'b0, fetch_addr} < load_count) ? ram[fetch_addr] : HALT;

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader and writable instruction store for the 4-bit CPU. Accepts a byte stream of 8-bit instructions from a host over a valid/ready handshake and writes them into a 16-entry instruction RAM. Validates the stream with an XOR checksum, then releases the CPU from reset. Exposes the same combinational fetch port the CPU core reads (4-bit address in, 8-bit instruction out), so it replaces the fixed ROM as the writer side of instruction memory.

## Interface
- DEPTH, 16, number of instruction words (fixed at 16 for a 4-bit PC)
- AW, 4, address width
- DW, 8, instruction width
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- start  in  1  single-cycle pulse; opens a load session
- in_valid  in  1  host byte valid
- in_data  in  DW  instruction or checksum byte
- in_last  in  1  qualifies in_data as final instruction byte (ignored in CHECK)
- in_ready  out  1  block accepts byte this cycle
- fetch_addr  in  AW  CPU PC
- fetch_instr  out  DW  instruction at fetch_addr, combinational
- cpu_reset  out  1  hold CPU in reset; registered
- busy  out  1  high in LOAD or CHECK
- done  out  1  high in RUN
- err  out  1  high in ERR
- load_count  out  AW+1  instruction bytes written this session (0..16)

## Operation
- States: IDLE, LOAD, CHECK, RUN, ERR. All outputs are decoded from the state register or driven by registers, except fetch_instr.
- Transfer = in_valid && in_ready on a rising edge.
- IDLE: in_ready=0, cpu_reset=1. start -> LOAD.
- LOAD: in_ready=1. Each transfer does three things: writes in_data to RAM[load_count], increments load_count, and XORs in_data into csum.
  - in_last=1 -> CHECK.
  - 16th transfer with in_last=0 -> ERR (overflow). That 16th byte is still written.
- CHECK: in_ready=1. On one transfer:
  - in_data == csum -> RUN.
  - Otherwise -> ERR.
  - RAM is not written in CHECK.
- RUN: cpu_reset=0, done=1, in_ready=0. start -> LOAD.
- ERR: cpu_reset=1, err=1, in_ready=0. start -> LOAD.
- Entering LOAD clears load_count to 0 and csum to 8'h00.
- start is ignored in LOAD and CHECK.
- fetch_instr = RAM[fetch_addr] when fetch_addr < load_count, else 8'hF0 (halt/no-writeback opcode). The whole map reads 8'hF0 after reset or start; stale RAM is never visible.
- RAM contents are not reset; validity is tracked only through load_count.
- load_count holds its final value in RUN and ERR.

## Timing
- Reset values: state=IDLE, cpu_reset=1, in_ready=0, busy=0, done=0, err=0, load_count=0, csum=0.
- Reset is asynchronous and may occur in any state, including mid-LOAD or mid-CHECK. The effect is immediate; a partial session is discarded (load_count=0).
- start sampled at edge N -> busy=1, in_ready=1 from cycle N+1.
- Byte write latency: RAM and load_count update at the accepting edge. fetch_instr reflects the new word in the following cycle.
- Checksum accepted at edge N -> done=1 and cpu_reset=0 from cycle N+1. The CPU executes its first fetch at address 0 on edge N+1 or later, depending on its own reset sampling.
- start in RUN at edge N -> cpu_reset=1 from cycle N+1. load_count=0 at the same time, so all fetches return 8'hF0.
- in_valid gaps are allowed in LOAD and CHECK. There is no timeout; the block waits indefinitely.
- Throughput: one byte per cycle.

## Test plan
- Happy path: start; send 01, 32, 11, F0 (in_last on F0); then checksum D2. Required: done=1 one cycle after the checksum; cpu_reset=0; load_count=4; fetch 0..3 = 01, 32, 11, F0; fetch 4..15 = F0.
- Bad checksum: same stream, checksum 00. Required: err=1, cpu_reset stays 1, load_count=4; a new start returns to LOAD with load_count=0.
- Overflow: 16 bytes 00..0F, in_last never set. Required: ERR after the 16th transfer, load_count=16, fetch 15 = 0F.
- Backpressure/gaps: happy-path bytes with in_valid low for 3 cycles between bytes, and start pulsed mid-LOAD. Required: identical final state to happy path; the mid-LOAD start has no effect.
- Reset mid-load: assert reset asynchronously (between edges) after 2 bytes. Required: in_ready, busy and load_count drop to 0 immediately; cpu_reset=1; fetch 0 = F0.
- Reload from RUN: after happy path, pulse start. Required: cpu_reset=1 next cycle; load 1 byte 23 (last) plus checksum 23 -> RUN, load_count=1, fetch 1 = F0.
